pixel_stream_packer: RTL and testbench
======================================

// Module: pixel_stream_packer
// PURPOSE
//  Downstream of the pixel coordinate/colour generator. Consumes one (x, y, colour) pixel per
//  accepted beat and checks it against the expected raster position. Emits a ready/valid video
//  stream with start-of-packet on the first pixel of each frame and end-of-packet on the last.
//  A FIFO absorbs sink back-pressure. Feeds the video output / frame-writer stage.
// PARAMETERS
//  DATA_WIDTH     32   width of in_x / in_y coordinate buses
//  RBG_SIZE       24   colour width, in and out
//  SCREEN_WIDTH   640  pixels per row; x runs 0..SCREEN_WIDTH-1
//  SCREEN_HEIGHT  480  rows per frame
//  FIRST_ROW      480  y of the first row; rows run FIRST_ROW down to FIRST_ROW-SCREEN_HEIGHT+1
//  FIFO_DEPTH     8    output buffer entries; power of two, >=2
// PORTS
//  clk          in   1           single clock, all logic on posedge
//  reset        in   1           synchronous, active-high
//  in_valid     in   1           upstream pixel present
//  in_ready     out  1           block can accept; = !fifo_full
//  in_x         in   DATA_WIDTH  pixel column
//  in_y         in   DATA_WIDTH  pixel row
//  in_colour    in   RBG_SIZE    pixel colour
//  out_data     out  RBG_SIZE    stream colour (FIFO head)
//  out_sop      out  1           head is first pixel of frame
//  out_eop      out  1           head is last pixel of frame
//  out_valid    out  1           = !fifo_empty
//  out_ready    in   1           sink accepts head this cycle
//  sync_err     out  1           one-cycle pulse on raster mismatch
//  frame_count  out  16          completed frames pushed with eop; wraps 0xFFFF->0
// BEHAVIOUR
//  - Accept = in_valid & in_ready. Pop = out_valid & out_ready. Both evaluated on the same edge.
//  - Reset: FIFO empty, out_valid=0, out_sop=0, out_eop=0, out_data=0, sync_err=0,
//    frame_count=0, state=SEEK, expected=(0,FIRST_ROW). Reset mid-frame drops all FIFO contents.
//  - FSM SEEK: accepted pixels are dropped unless (in_x==0 && in_y==FIRST_ROW). That pixel is
//    pushed with sop=1 -> STREAM, expected=(1,FIRST_ROW).
//  - FSM STREAM: accepted pixel compared (full DATA_WIDTH) to expected.
//    * Match: push {colour, sop, eop}. sop=1 iff (0,FIRST_ROW). eop=1 iff
//      (SCREEN_WIDTH-1, FIRST_ROW-SCREEN_HEIGHT+1). Expected advances x+1. At
//      x==SCREEN_WIDTH-1: x=0, y-1. After the eop pixel: expected=(0,FIRST_ROW), remain STREAM.
//      frame_count+1 on the cycle the eop pixel is pushed.
//    * Mismatch: sync_err=1 next cycle. If pixel is (0,FIRST_ROW), push it with sop=1 and
//      restart expected=(1,FIRST_ROW). Otherwise drop it -> SEEK. The open packet is left
//      without eop; the sink detects this via the next sop.
//  - Non-accepted cycles: no state change. Coordinates are not checked.
//  - FIFO: first-word fall-through; head visible same cycle out_valid=1. Push-to-out_valid
//    latency is 1 cycle. Push and pop in the same cycle are allowed when not full/empty. A push
//    cannot occur when full because in_ready=0. Pop when empty is ignored.
//  - Full throughput: 1 pixel/cycle while out_ready=1.
//  - out_sop/out_eop/out_data are meaningful only when out_valid=1. They are held stable while
//    out_valid=1 & out_ready=0.
// TESTING
//  - Reset, then a full 640x480 raster with out_ready=1 -> 307200 beats. sop only on beat 0,
//    eop only on beat 307199. frame_count=1. sync_err never set.
//  - Start mid-frame at (100,300) -> all dropped until (0,480). First output beat has sop=1.
//  - Skip pixel (5,480) in a raster -> sync_err pulse at (6,480). Pixels dropped until the next
//    (0,480), which restarts with sop.
//  - out_ready=0 for 20 cycles with continuous input -> in_ready low after FIFO_DEPTH pushes.
//    No beat lost or duplicated, and order is preserved on release.
//  - Assert reset mid-frame with FIFO holding 5 entries -> next cycle out_valid=0, frame_count=0,
//    state SEEK.
//  - Run 2 back-to-back frames -> second frame's sop directly follows first eop. frame_count=2.

Source files
------------

// File: rtl/pixel_stream_packer_if.sv
// rtl/pixel_stream_packer_if.sv - pixel input and video stream output bundle
// slave is the packer side, master is the upstream generator / sink side.
interface pixel_stream_packer_if #(
   parameter int DATA_WIDTH = 32,
   parameter int RBG_SIZE   = 24
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_x;
   logic [DATA_WIDTH-1:0] in_y;
   logic [RBG_SIZE-1:0]   in_colour;
   logic [RBG_SIZE-1:0]   out_data;
   logic                  out_sop;
   logic                  out_eop;
   logic                  out_valid;
   logic                  out_ready;
   logic                  sync_err;
   logic [15:0]           frame_count;

   modport slave (
      input  in_valid, in_x, in_y, in_colour, out_ready,
      output in_ready, out_data, out_sop, out_eop, out_valid, sync_err, frame_count
   );

   modport master (
      output in_valid, in_x, in_y, in_colour, out_ready,
      input  in_ready, out_data, out_sop, out_eop, out_valid, sync_err, frame_count
   );
endinterface

// File: rtl/pixel_stream_packer.sv
// rtl/pixel_stream_packer.sv - raster-checked pixel to sop/eop video stream packer
// Pixels are checked against the expected raster position and buffered in a fall-through FIFO.
module pixel_stream_packer #(
   parameter int DATA_WIDTH    = 32,
   parameter int RBG_SIZE      = 24,
   parameter int SCREEN_WIDTH  = 640,
   parameter int SCREEN_HEIGHT = 480,
   parameter int FIRST_ROW     = 480,
   parameter int FIFO_DEPTH    = 8
) (
   input logic                  clk,
   input logic                  reset,
   pixel_stream_packer_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = RBG_SIZE + 2;
   localparam logic [DATA_WIDTH-1:0] LP_FIRST_ROW = DATA_WIDTH'(FIRST_ROW);
   localparam logic [DATA_WIDTH-1:0] LP_LAST_ROW  = DATA_WIDTH'(FIRST_ROW - SCREEN_HEIGHT + 1);
   localparam logic [DATA_WIDTH-1:0] LP_LAST_X    = DATA_WIDTH'(SCREEN_WIDTH - 1);
   localparam logic [DATA_WIDTH-1:0] LP_ONE       = DATA_WIDTH'(1);
   localparam logic [AW:0]           LP_DEPTH     = (AW+1)'(FIFO_DEPTH);

   typedef enum logic {ST_SEEK, ST_STREAM} state_t;

   state_t                r_state;
   state_t                w_state_nx;
   logic [DATA_WIDTH-1:0] r_exp_x;
   logic [DATA_WIDTH-1:0] r_exp_y;
   logic [DATA_WIDTH-1:0] w_exp_x_nx;
   logic [DATA_WIDTH-1:0] w_exp_y_nx;

   logic [EW-1:0]         r_mem [FIFO_DEPTH];
   logic [AW-1:0]         r_wr_ptr;
   logic [AW-1:0]         r_rd_ptr;
   logic [AW:0]           r_count;
   logic                  r_sync_err;
   logic [15:0]           r_frame_count;

   logic                  w_full;
   logic                  w_empty;
   logic                  w_accept;
   logic                  w_pop;
   logic                  w_push;
   logic                  w_push_sop;
   logic                  w_push_eop;
   logic                  w_err;
   logic                  w_is_first;
   logic                  w_is_last;
   logic                  w_match;
   logic [EW-1:0]         w_head;

   assign w_full     = (r_count == LP_DEPTH);
   assign w_empty    = (r_count == '0);
   assign w_accept   = bus.in_valid & ~w_full;
   assign w_pop      = ~w_empty & bus.out_ready;
   assign w_is_first = (bus.in_x == '0) && (bus.in_y == LP_FIRST_ROW);
   assign w_is_last  = (bus.in_x == LP_LAST_X) && (bus.in_y == LP_LAST_ROW);
   assign w_match    = (bus.in_x == r_exp_x) && (bus.in_y == r_exp_y);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_SEEK;
         r_exp_x <= '0;
         r_exp_y <= LP_FIRST_ROW;
      end else begin
         r_state <= w_state_nx;
         r_exp_x <= w_exp_x_nx;
         r_exp_y <= w_exp_y_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_exp_x_nx = r_exp_x;
      w_exp_y_nx = r_exp_y;
      w_push     = 1'b0;
      w_push_sop = 1'b0;
      w_push_eop = 1'b0;
      w_err      = 1'b0;
      if (w_accept) begin
         case (r_state)
            ST_SEEK: begin
               if (w_is_first) begin
                  w_push     = 1'b1;
                  w_push_sop = 1'b1;
                  w_state_nx = ST_STREAM;
                  w_exp_x_nx = LP_ONE;
                  w_exp_y_nx = LP_FIRST_ROW;
               end
            end
            ST_STREAM: begin
               if (w_match) begin
                  w_push     = 1'b1;
                  w_push_sop = w_is_first;
                  w_push_eop = w_is_last;
                  if (w_is_last) begin
                     w_exp_x_nx = '0;
                     w_exp_y_nx = LP_FIRST_ROW;
                  end else if (r_exp_x == LP_LAST_X) begin
                     w_exp_x_nx = '0;
                     w_exp_y_nx = r_exp_y - LP_ONE;
                  end else begin
                     w_exp_x_nx = r_exp_x + LP_ONE;
                  end
               end else begin
                  // A misplaced frame-start pixel resyncs immediately instead of via SEEK.
                  w_err = 1'b1;
                  if (w_is_first) begin
                     w_push     = 1'b1;
                     w_push_sop = 1'b1;
                     w_exp_x_nx = LP_ONE;
                     w_exp_y_nx = LP_FIRST_ROW;
                  end else begin
                     w_state_nx = ST_SEEK;
                     w_exp_x_nx = '0;
                     w_exp_y_nx = LP_FIRST_ROW;
                  end
               end
            end
            default: w_state_nx = ST_SEEK;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {bus.in_colour, w_push_sop, w_push_eop};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
         r_sync_err    <= 1'b0;
         r_frame_count <= '0;
      end else begin
         r_sync_err <= w_err;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (w_push && w_push_eop) begin
            r_frame_count <= r_frame_count + 16'd1;
         end
      end
   end

   // Head fields are forced to zero while empty so reset presents clean outputs.
   assign w_head          = r_mem[r_rd_ptr];
   assign bus.in_ready    = ~w_full;
   assign bus.out_valid   = ~w_empty;
   assign bus.out_data    = w_empty ? '0 : w_head[EW-1:2];
   assign bus.out_sop     = ~w_empty & w_head[1];
   assign bus.out_eop     = ~w_empty & w_head[0];
   assign bus.sync_err    = r_sync_err;
   assign bus.frame_count = r_frame_count;
endmodule

// File: tb/tb_pixel_stream_packer.sv
// tb/tb_pixel_stream_packer.sv - directed bench for pixel_stream_packer on a reduced 8x4 raster
module tb_pixel_stream_packer;
   localparam int DW    = 32;
   localparam int CW    = 24;
   localparam int SW    = 8;
   localparam int SH    = 4;
   localparam int FR    = 480;
   localparam int DEPTH = 8;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   pixel_stream_packer_if #(.DATA_WIDTH(DW), .RBG_SIZE(CW)) bus ();

   pixel_stream_packer #(
      .DATA_WIDTH(DW), .RBG_SIZE(CW), .SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH),
      .FIRST_ROW(FR), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int n_checks   = 0;
   int n_pass     = 0;
   int err_pulses = 0;
   int n_acc      = 0;
   logic [CW+1:0] got_q[$];
   logic [CW+1:0] exp_q[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (bus.out_valid && bus.out_ready)
            got_q.push_back({bus.out_data, bus.out_sop, bus.out_eop});
         if (bus.sync_err) err_pulses++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [CW-1:0] colour(input int x, input int y, input int f);
      return {f[7:0], y[7:0], x[7:0]};
   endfunction

   task automatic send_px(input int x, input int y, input int f, input bit keep,
                          input bit sop, input bit eop);
      int n = 0;
      bus.in_valid  = 1'b1;
      bus.in_x      = DW'(x);
      bus.in_y      = DW'(y);
      bus.in_colour = colour(x, y, f);
      while (!bus.in_ready && n < 500) begin
         tick();
         n++;
      end
      if (n >= 500) check("in_ready_timeout", 0, 1);
      tick();
      n_acc++;
      bus.in_valid = 1'b0;
      if (keep) exp_q.push_back({colour(x, y, f), sop, eop});
   endtask

   task automatic send_frame(input int f);
      for (int r = 0; r < SH; r++)
         for (int c = 0; c < SW; c++)
            send_px(c, FR - r, f, 1'b1, (r == 0 && c == 0), (r == SH-1 && c == SW-1));
   endtask

   task automatic drain();
      int n = 0;
      while (bus.out_valid && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) check("drain_timeout", 0, 1);
      tick();
      tick();
   endtask

   task automatic compare(input string tag);
      check($sformatf("%s_beats", tag), got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         check($sformatf("%s[%0d]", tag, i), got_q[i], exp_q[i]);
   endtask

   task automatic start_test();
      reset        = 1'b1;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      got_q.delete();
      exp_q.delete();
      err_pulses = 0;
      n_acc      = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_x      = '0;
      bus.in_y      = '0;
      bus.in_colour = '0;
      bus.out_ready = 1'b1;

      // reset state
      start_test();
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_sop", bus.out_sop, 0);
      check("rst_out_eop", bus.out_eop, 0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_sync_err", bus.sync_err, 0);
      check("rst_frame_count", bus.frame_count, 0);
      check("rst_in_ready", bus.in_ready, 1);

      // one clean frame
      start_test();
      send_frame(1);
      drain();
      compare("t1");
      check("t1_frame_count", bus.frame_count, 1);
      check("t1_err_pulses", err_pulses, 0);

      // mid-frame start: everything before (0,FR) is dropped silently
      start_test();
      send_px(100, 300, 2, 1'b0, 1'b0, 1'b0);
      send_px(101, 300, 2, 1'b0, 1'b0, 1'b0);
      send_px(3, FR-1, 2, 1'b0, 1'b0, 1'b0);
      send_px(0, FR-1, 2, 1'b0, 1'b0, 1'b0);
      send_frame(2);
      drain();
      compare("t2");
      check("t2_frame_count", bus.frame_count, 1);
      check("t2_err_pulses", err_pulses, 0);

      // skipped pixel (5,FR): error on (6,FR), rest of frame dropped
      start_test();
      for (int c = 0; c < 5; c++) send_px(c, FR, 3, 1'b1, (c == 0), 1'b0);
      send_px(6, FR, 3, 1'b0, 1'b0, 1'b0);
      check("t3_err_pulse", bus.sync_err, 1);
      send_px(7, FR, 3, 1'b0, 1'b0, 1'b0);
      check("t3_err_single", bus.sync_err, 0);
      for (int r = 1; r < SH; r++)
         for (int c = 0; c < SW; c++) send_px(c, FR - r, 3, 1'b0, 1'b0, 1'b0);
      send_frame(4);
      drain();
      compare("t3");
      check("t3_frame_count", bus.frame_count, 1);
      check("t3_err_pulses", err_pulses, 1);

      // back-pressure: sink stalled for 20 cycles with continuous input
      start_test();
      bus.out_ready = 1'b0;
      fork
         send_frame(5);
         begin
            repeat (20) tick();
            check("t4_in_ready", bus.in_ready, 0);
            check("t4_accepted", n_acc, DEPTH);
            check("t4_out_valid", bus.out_valid, 1);
            check("t4_head", {bus.out_data, bus.out_sop, bus.out_eop},
                  {colour(0, FR, 5), 1'b1, 1'b0});
            bus.out_ready = 1'b1;
         end
      join
      drain();
      compare("t4");
      check("t4_frame_count", bus.frame_count, 1);

      // reset mid-frame with 5 entries buffered
      start_test();
      send_frame(6);
      drain();
      compare("t5_pre");
      check("t5_pre_frame_count", bus.frame_count, 1);
      bus.out_ready = 1'b0;
      for (int c = 0; c < 5; c++) send_px(c, FR, 7, 1'b0, 1'b0, 1'b0);
      check("t5_buffered", bus.out_valid, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t5_out_valid", bus.out_valid, 0);
      check("t5_frame_count", bus.frame_count, 0);
      check("t5_in_ready", bus.in_ready, 1);
      check("t5_out_sop", bus.out_sop, 0);
      got_q.delete();
      err_pulses    = 0;
      bus.out_ready = 1'b1;
      send_px(2, FR, 7, 1'b0, 1'b0, 1'b0);
      send_px(5, FR-1, 7, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      check("t5_seek_drop", got_q.size(), 0);
      check("t5_seek_no_err", err_pulses, 0);

      // two back-to-back frames
      start_test();
      send_frame(8);
      send_frame(9);
      drain();
      compare("t6");
      check("t6_frame_count", bus.frame_count, 2);
      check("t6_err_pulses", err_pulses, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
